// File: rtl/tqvp_rsa_modexp_wide.sv
// Byte-windowed modular exponentiation peripheral: C = P^E mod M, left-to-right square-and-multiply
// built on a bit-serial interleaved modular multiplier; every valid run takes 1 + 2*WIDTH*WIDTH cycles.
module tqvp_rsa_modexp_wide #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       user_interrupt
);
    localparam int NBYTES = WIDTH / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CNT_W  = $clog2(WIDTH);
    localparam int AW     = WIDTH + 2;

    localparam logic [3:0] ADDR_CTRL   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h1;
    localparam logic [3:0] ADDR_SEL    = 4'h2;
    localparam logic [3:0] ADDR_INDEX  = 4'h3;
    localparam logic [3:0] ADDR_DATA   = 4'h4;
    localparam logic [3:0] ADDR_IRQ_EN = 4'h5;

    localparam logic [1:0] SEL_P = 2'd0;
    localparam logic [1:0] SEL_E = 2'd1;
    localparam logic [1:0] SEL_M = 2'd2;
    localparam logic [1:0] SEL_C = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_SQR, ST_MUL} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] p_q, p_d, e_q, e_d, m_q, m_d, c_q, c_d, r_q, r_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] k_q, k_d, cnt_q, cnt_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [1:0]       sel_q, sel_d;
    logic             irq_en_q, irq_en_d, done_q, done_d, error_q, error_d;

    logic             busy, ctrl_wr, start_req, abort_req, clear_req;
    logic             last_bit, operand_err, e_bit, b_bit;
    logic [WIDTH-1:0] mm_b, mm_res, sel_op;
    logic [AW-1:0]    m_ext, t_sum, t_sub1, acc_next;
    logic [IDX_W-1:0] index_inc;
    logic [7:0]       sel_byte;
    logic             unused_ui;

    assign unused_ui   = ^ui_in;
    assign ctrl_wr     = data_write && (address == ADDR_CTRL);
    assign abort_req   = ctrl_wr && data_in[1];
    assign start_req   = ctrl_wr && data_in[0] && !data_in[1];
    assign clear_req   = ctrl_wr && data_in[2];
    assign last_bit    = (cnt_q == CNT_W'(WIDTH - 1));
    assign operand_err = (m_q == '0) || (p_q >= m_q);
    assign e_bit       = e_q[k_q];
    assign index_inc   = (index_q == IDX_W'(NBYTES - 1)) ? '0 : index_q + IDX_W'(1);

    // One step of the interleaved multiplier: acc stays below M, so 2*acc + A < 3M and two
    // conditional subtractions always bring it back under M.
    always_comb begin
        mm_b     = (state_q == ST_SQR) ? r_q : p_q;
        b_bit    = mm_b[CNT_W'(WIDTH - 1) - cnt_q];
        m_ext    = {2'b00, m_q};
        t_sum    = (acc_q << 1) + (b_bit ? {2'b00, r_q} : '0);
        t_sub1   = (t_sum >= m_ext) ? t_sum - m_ext : t_sum;
        acc_next = (t_sub1 >= m_ext) ? t_sub1 - m_ext : t_sub1;
        mm_res   = acc_next[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_req) state_d = ST_CHECK;
            ST_CHECK: state_d = (abort_req || operand_err) ? ST_IDLE : ST_SQR;
            ST_SQR: begin
                if (abort_req)     state_d = ST_IDLE;
                else if (last_bit) state_d = ST_MUL;
            end
            ST_MUL: begin
                if (abort_req)     state_d = ST_IDLE;
                else if (last_bit) state_d = (k_q == '0) ? ST_IDLE : ST_SQR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy           = (state_q != ST_IDLE);
        uo_out         = {busy, done_q, error_q, 5'b0};
        user_interrupt = done_q & irq_en_q;
        case (sel_q)
            SEL_P:   sel_op = p_q;
            SEL_E:   sel_op = e_q;
            SEL_M:   sel_op = m_q;
            default: sel_op = c_q;
        endcase
        sel_byte = '0;
        for (int b = 0; b < NBYTES; b++)
            if (index_q == IDX_W'(b)) sel_byte = sel_op[8*b +: 8];
        case (address)
            ADDR_STATUS: data_out = {5'b0, error_q, done_q, busy};
            ADDR_SEL:    data_out = {6'b0, sel_q};
            ADDR_INDEX:  data_out = 8'(index_q);
            ADDR_DATA:   data_out = sel_byte;
            ADDR_IRQ_EN: data_out = {7'b0, irq_en_q};
            default:     data_out = '0;
        endcase
    end

    always_comb begin
        // NOTE: every _d starts from its held value so no branch below can leave one unassigned and infer a latch.
        p_d = p_q;   e_d = e_q;   m_d = m_q;   c_d = c_q;   r_d = r_q;
        acc_d = acc_q;   k_d = k_q;   cnt_d = cnt_q;
        index_d = index_q;   sel_d = sel_q;   irq_en_d = irq_en_q;
        done_d = done_q;   error_d = error_q;

        if (data_write) begin
            case (address)
                ADDR_SEL:    sel_d = data_in[1:0];
                ADDR_INDEX:  index_d = (int'(data_in) < NBYTES) ? data_in[IDX_W-1:0] : '0;
                ADDR_IRQ_EN: irq_en_d = data_in[0];
                ADDR_DATA: begin
                    if (!busy && sel_q != SEL_C) begin
                        for (int b = 0; b < NBYTES; b++) begin
                            if (index_q == IDX_W'(b)) begin
                                case (sel_q)
                                    SEL_P:   p_d[8*b +: 8] = data_in;
                                    SEL_E:   e_d[8*b +: 8] = data_in;
                                    default: m_d[8*b +: 8] = data_in;
                                endcase
                            end
                        end
                    end
                    index_d = index_inc;
                end
                default: ;
            endcase
        end

        if (clear_req) begin
            done_d  = 1'b0;
            error_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    r_d     = (m_q == WIDTH'(1)) ? '0 : WIDTH'(1);
                    k_d     = CNT_W'(WIDTH - 1);
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            ST_CHECK: begin
                if (!abort_req && operand_err) begin
                    done_d  = 1'b1;
                    error_d = 1'b1;
                    c_d     = '0;
                end
            end
            default: begin
                if (!abort_req) begin
                    if (last_bit) begin
                        cnt_d = '0;
                        acc_d = '0;
                        if (state_q == ST_SQR) begin
                            r_d = mm_res;
                        end else begin
                            // The multiply always runs; E[k] only decides whether its product is kept.
                            if (e_bit) r_d = mm_res;
                            if (k_q == '0) begin
                                c_d    = e_bit ? mm_res : r_q;
                                done_d = 1'b1;
                            end else begin
                                k_d = k_q - CNT_W'(1);
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        acc_d = acc_next;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            p_q <= '0;   e_q <= '0;   m_q <= '0;   c_q <= '0;   r_q <= '0;
            acc_q <= '0;   k_q <= '0;   cnt_q <= '0;
            index_q <= '0;   sel_q <= '0;   irq_en_q <= 1'b0;
            done_q <= 1'b0;   error_q <= 1'b0;
        end else begin
            p_q <= p_d;   e_q <= e_d;   m_q <= m_d;   c_q <= c_d;   r_q <= r_d;
            acc_q <= acc_d;   k_q <= k_d;   cnt_q <= cnt_d;
            index_q <= index_d;   sel_q <= sel_d;   irq_en_q <= irq_en_d;
            done_q <= done_d;   error_q <= error_d;
        end
    end
endmodule

// File: tb/tb_tqvp_rsa_modexp_wide.sv
// Scoreboard bench for tqvp_rsa_modexp_wide at WIDTH = 16, 8 and 24; expectations come from a
// right-to-left modexp model and the register-map rules.
module tb_tqvp_rsa_modexp_wide;
    localparam int I16 = 0;
    localparam int I8  = 1;
    localparam int I24 = 2;

    localparam logic [3:0] A_CTRL   = 4'h0;
    localparam logic [3:0] A_STATUS = 4'h1;
    localparam logic [3:0] A_SEL    = 4'h2;
    localparam logic [3:0] A_INDEX  = 4'h3;
    localparam logic [3:0] A_DATA   = 4'h4;
    localparam logic [3:0] A_IRQ_EN = 4'h5;

    typedef struct {
        logic [63:0] c;
        bit          err;
        int          lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ui_in = '0;
    logic [3:0] address = '0;
    logic [7:0] data_in = '0;
    logic       dw16 = 1'b0, dw8 = 1'b0, dw24 = 1'b0;
    logic [7:0] uo16, uo8, uo24, do16, do8, do24;
    logic       irq16, irq8, irq24;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   busy_cnt [3] = '{0, 0, 0};
    int   run_base [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    tqvp_rsa_modexp_wide #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo16), .address(address),
        .data_write(dw16), .data_in(data_in), .data_out(do16), .user_interrupt(irq16));
    tqvp_rsa_modexp_wide #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo8), .address(address),
        .data_write(dw8), .data_in(data_in), .data_out(do8), .user_interrupt(irq8));
    tqvp_rsa_modexp_wide #(.WIDTH(24)) u_w24 (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo24), .address(address),
        .data_write(dw24), .data_in(data_in), .data_out(do24), .user_interrupt(irq24));

    always @(negedge clk) begin
        if (uo16[7] === 1'b1) busy_cnt[I16]++;
        if (uo8[7]  === 1'b1) busy_cnt[I8]++;
        if (uo24[7] === 1'b1) busy_cnt[I24]++;
    end

    function automatic int nbytes(input int inst);
        return (inst == I16) ? 2 : (inst == I8) ? 1 : 3;
    endfunction

    function automatic logic [7:0] uo_of(input int inst);
        return (inst == I16) ? uo16 : (inst == I8) ? uo8 : uo24;
    endfunction

    function automatic logic irq_of(input int inst);
        return (inst == I16) ? irq16 : (inst == I8) ? irq8 : irq24;
    endfunction

    function automatic logic busy_of(input int inst);
        logic [7:0] u;
        u = uo_of(inst);
        return u[7];
    endfunction

    function automatic logic done_of(input int inst);
        logic [7:0] u;
        u = uo_of(inst);
        return u[6];
    endfunction

    function automatic logic err_of(input int inst);
        logic [7:0] u;
        u = uo_of(inst);
        return u[5];
    endfunction

    // Right-to-left binary exponentiation, independent of the DUT's left-to-right schedule.
    function automatic logic [63:0] model_modexp(input logic [63:0] p, e, m, input int w);
        logic [63:0] res, base;
        if (m == 64'd0 || p >= m) return 64'd0;
        res  = 64'd1 % m;
        base = p;
        for (int i = 0; i < w; i++) begin
            if (e[i]) res = (res * base) % m;
            base = (base * base) % m;
        end
        return res;
    endfunction

    task automatic bus_write(input int inst, input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        address = a;
        data_in = d;
        dw16 = (inst == I16);
        dw8  = (inst == I8);
        dw24 = (inst == I24);
        @(negedge clk);
        dw16 = 1'b0;
        dw8  = 1'b0;
        dw24 = 1'b0;
    endtask

    task automatic bus_read(input int inst, input logic [3:0] a, output logic [7:0] d);
        address = a;
        #1;
        d = (inst == I16) ? do16 : (inst == I8) ? do8 : do24;
    endtask

    task automatic load_operand(input int inst, input logic [1:0] sel, input logic [63:0] val);
        bus_write(inst, A_SEL, {6'b0, sel});
        bus_write(inst, A_INDEX, 8'h00);
        for (int b = 0; b < nbytes(inst); b++) bus_write(inst, A_DATA, val[8*b +: 8]);
    endtask

    task automatic read_operand(input int inst, input logic [1:0] sel, output logic [63:0] val);
        logic [7:0] d;
        val = '0;
        bus_write(inst, A_SEL, {6'b0, sel});
        for (int b = 0; b < nbytes(inst); b++) begin
            bus_write(inst, A_INDEX, 8'(b));
            bus_read(inst, A_DATA, d);
            val[8*b +: 8] = d;
        end
    endtask

    task automatic start_run(input int inst, input logic [63:0] p, e, m, input bit expect_done);
        exp_t x;
        int   w;
        w = 8 * nbytes(inst);
        load_operand(inst, 2'd0, p);
        load_operand(inst, 2'd1, e);
        load_operand(inst, 2'd2, m);
        if (expect_done) begin
            x.err = (m == 64'd0) || (p >= m);
            x.c   = model_modexp(p, e, m, w);
            x.lat = x.err ? 1 : 1 + 2 * w * w;
            sb.push_back(x);
        end
        run_base[inst] = busy_cnt[inst];
        bus_write(inst, A_CTRL, 8'h01);
    endtask

    task automatic finish_run(input int inst, input string name);
        exp_t        x;
        int          guard;
        int          lat;
        logic [63:0] c_val;
        guard = 0;
        while (busy_of(inst) === 1'b1 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (busy_of(inst) !== 1'b0) begin
            failures++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy_of(inst), guard);
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s_scoreboard: queue size 0, required >= 1", name);
            return;
        end
        x = sb.pop_front();
        lat = busy_cnt[inst] - run_base[inst];
        checks++;
        if (lat !== x.lat) begin
            failures++;
            $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, x.lat);
        end
        checks++;
        if (done_of(inst) !== 1'b1) begin
            failures++;
            $display("FAIL %s_done: got %b, required 1", name, done_of(inst));
        end
        checks++;
        if (err_of(inst) !== x.err) begin
            failures++;
            $display("FAIL %s_error: got %b, required %b", name, err_of(inst), x.err);
        end
        read_operand(inst, 2'd3, c_val);
        checks++;
        if (c_val !== x.c) begin
            failures++;
            $display("FAIL %s_result: got %0d, required %0d", name, c_val, x.c);
        end
    endtask

    task automatic test_reset();
        logic [7:0]  d;
        logic [63:0] v;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (uo_of(i) !== 8'h00) begin
                failures++;
                $display("FAIL reset_uo_%0d: got %h, required 00", i, uo_of(i));
            end
            checks++;
            if (irq_of(i) !== 1'b0) begin
                failures++;
                $display("FAIL reset_irq_%0d: got %b, required 0", i, irq_of(i));
            end
            bus_read(i, A_SEL, d);
            checks++;
            if (d !== 8'h00) begin
                failures++;
                $display("FAIL reset_sel_%0d: got %h, required 00", i, d);
            end
            bus_read(i, A_IRQ_EN, d);
            checks++;
            if (d !== 8'h00) begin
                failures++;
                $display("FAIL reset_irq_en_%0d: got %h, required 00", i, d);
            end
            read_operand(i, 2'd2, v);
            checks++;
            if (v !== 64'd0) begin
                failures++;
                $display("FAIL reset_m_%0d: got %h, required 0", i, v);
            end
        end
    endtask

    task automatic test_modexp_16();
        logic [7:0] d;
        start_run(I16, 64'd4, 64'd13, 64'd497, 1'b1);
        finish_run(I16, "w16_4_13_497");
        bus_write(I16, A_SEL, 8'h03);
        bus_write(I16, A_INDEX, 8'h00);
        bus_read(I16, A_DATA, d);
        checks++;
        if (d !== 8'hBD) begin
            failures++;
            $display("FAIL w16_c_byte0: got %h, required bd", d);
        end
        bus_write(I16, A_INDEX, 8'h01);
        bus_read(I16, A_DATA, d);
        checks++;
        if (d !== 8'h01) begin
            failures++;
            $display("FAIL w16_c_byte1: got %h, required 01", d);
        end
    endtask

    task automatic test_modexp_8();
        start_run(I8, 64'd7, 64'd3, 64'd33, 1'b1);
        finish_run(I8, "w8_7_3_33");
        start_run(I8, 64'd7, 64'd0, 64'd33, 1'b1);
        finish_run(I8, "w8_e0");
        start_run(I8, 64'd0, 64'd3, 64'd1, 1'b1);
        finish_run(I8, "w8_m1");
    endtask

    task automatic test_error();
        start_run(I8, 64'd7, 64'd3, 64'd33, 1'b1);
        finish_run(I8, "err_pre");
        start_run(I8, 64'd40, 64'd3, 64'd33, 1'b1);
        finish_run(I8, "err_p_ge_m");
        start_run(I8, 64'd7, 64'd3, 64'd33, 1'b1);
        finish_run(I8, "err_pre2");
        start_run(I8, 64'd5, 64'd3, 64'd0, 1'b1);
        finish_run(I8, "err_m0");
    endtask

    task automatic test_irq();
        bit seen;
        int guard;
        bus_write(I8, A_IRQ_EN, 8'h01);
        start_run(I8, 64'd3, 64'd4, 64'd33, 1'b1);
        seen = 1'b0;
        guard = 0;
        while (busy_of(I8) === 1'b1 && guard < 1000) begin
            if (irq8 !== 1'b0) seen = 1'b1;
            @(negedge clk);
            guard++;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL irq_early: got 1 while busy, required 0");
        end
        finish_run(I8, "irq_run");
        checks++;
        if (irq8 !== 1'b1) begin
            failures++;
            $display("FAIL irq_rise: got %b, required 1", irq8);
        end
        bus_write(I8, A_CTRL, 8'h04);
        checks++;
        if (irq8 !== 1'b0 || done_of(I8) !== 1'b0) begin
            failures++;
            $display("FAIL irq_clear: got irq=%b done=%b, required 0 0", irq8, done_of(I8));
        end
        bus_write(I8, A_IRQ_EN, 8'h00);
        start_run(I8, 64'd5, 64'd2, 64'd33, 1'b1);
        seen = 1'b0;
        guard = 0;
        while (busy_of(I8) === 1'b1 && guard < 1000) begin
            @(negedge clk);
            if (irq8 !== 1'b0) seen = 1'b1;
            guard++;
        end
        finish_run(I8, "irq_off_run");
        checks++;
        if (seen || irq8 !== 1'b0) begin
            failures++;
            $display("FAIL irq_masked: got seen=%b irq=%b, required 0 0", seen, irq8);
        end
    endtask

    task automatic test_abort();
        logic [63:0] v;
        start_run(I8, 64'd7, 64'd3, 64'd33, 1'b1);
        finish_run(I8, "abort_pre");
        start_run(I8, 64'd2, 64'd7, 64'd33, 1'b0);
        repeat (47) @(negedge clk);
        bus_write(I8, A_CTRL, 8'h02);
        checks++;
        if (busy_of(I8) !== 1'b0 || done_of(I8) !== 1'b0) begin
            failures++;
            $display("FAIL abort_status: got busy=%b done=%b, required 0 0", busy_of(I8), done_of(I8));
        end
        read_operand(I8, 2'd3, v);
        checks++;
        if (v !== 64'd13) begin
            failures++;
            $display("FAIL abort_c_kept: got %0d, required 13", v);
        end
        bus_write(I8, A_CTRL, 8'h03);
        repeat (3) @(negedge clk);
        checks++;
        if (busy_of(I8) !== 1'b0) begin
            failures++;
            $display("FAIL abort_beats_start: got busy=%b, required 0", busy_of(I8));
        end
        start_run(I8, 64'd2, 64'd7, 64'd33, 1'b1);
        finish_run(I8, "after_abort");
    endtask

    task automatic test_back_to_back();
        logic [63:0] v;
        start_run(I8, 64'd7, 64'd3, 64'd33, 1'b1);
        repeat (20) @(negedge clk);
        bus_write(I8, A_CTRL, 8'h01);
        load_operand(I8, 2'd0, 64'd5);
        finish_run(I8, "busy_writes");
        read_operand(I8, 2'd0, v);
        checks++;
        if (v !== 64'd7) begin
            failures++;
            $display("FAIL busy_p_kept: got %0d, required 7", v);
        end
        start_run(I8, 64'd2, 64'd5, 64'd33, 1'b1);
        checks++;
        if (busy_of(I8) !== 1'b1 || done_of(I8) !== 1'b0) begin
            failures++;
            $display("FAIL restart_status: got busy=%b done=%b, required 1 0", busy_of(I8), done_of(I8));
        end
        finish_run(I8, "restart");
    endtask

    task automatic test_index();
        logic [7:0]  d;
        logic [63:0] v;
        start_run(I24, 64'd123456, 64'd65537, 64'd1000003, 1'b1);
        finish_run(I24, "w24_run");
        bus_write(I24, A_INDEX, 8'h05);
        bus_read(I24, A_INDEX, d);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("FAIL index_oob: got %h, required 00", d);
        end
        bus_write(I24, A_INDEX, 8'h02);
        bus_read(I24, A_INDEX, d);
        checks++;
        if (d !== 8'h02) begin
            failures++;
            $display("FAIL index_set: got %h, required 02", d);
        end
        bus_write(I24, A_SEL, 8'h00);
        bus_write(I24, A_INDEX, 8'h00);
        bus_write(I24, A_DATA, 8'h11);
        bus_write(I24, A_DATA, 8'h22);
        bus_write(I24, A_DATA, 8'h33);
        bus_read(I24, A_INDEX, d);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("FAIL index_wrap: got %h, required 00", d);
        end
        bus_write(I24, A_SEL, 8'h03);
        bus_write(I24, A_INDEX, 8'h01);
        bus_write(I24, A_DATA, 8'hAA);
        bus_read(I24, A_INDEX, d);
        checks++;
        if (d !== 8'h02) begin
            failures++;
            $display("FAIL index_c_write_inc: got %h, required 02", d);
        end
        read_operand(I24, 2'd3, v);
        checks++;
        if (v !== model_modexp(64'd123456, 64'd65537, 64'd1000003, 24)) begin
            failures++;
            $display("FAIL c_readonly: got %0d, required %0d", v,
                     model_modexp(64'd123456, 64'd65537, 64'd1000003, 24));
        end
        read_operand(I24, 2'd0, v);
        checks++;
        if (v !== 64'h332211) begin
            failures++;
            $display("FAIL p_bytes: got %h, required 332211", v);
        end
        bus_read(I24, 4'h6, d);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("FAIL unmapped_read: got %h, required 00", d);
        end
    endtask

    task automatic test_reset_midrun();
        logic [63:0] v;
        logic [7:0]  d;
        bus_write(I8, A_IRQ_EN, 8'h01);
        start_run(I16, 64'd4, 64'd13, 64'd497, 1'b0);
        repeat (30) @(negedge clk);
        checks++;
        if (busy_of(I16) !== 1'b1) begin
            failures++;
            $display("FAIL midrun_busy: got %b, required 1", busy_of(I16));
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (uo_of(i) !== 8'h00 || irq_of(i) !== 1'b0) begin
                failures++;
                $display("FAIL midrun_reset_out_%0d: got uo=%h irq=%b, required 00 0", i, uo_of(i), irq_of(i));
            end
        end
        read_operand(I16, 2'd3, v);
        checks++;
        if (v !== 64'd0) begin
            failures++;
            $display("FAIL midrun_reset_c: got %0d, required 0", v);
        end
        bus_read(I8, A_IRQ_EN, d);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("FAIL midrun_reset_irq_en: got %h, required 00", d);
        end
    endtask

    initial begin
        test_reset();
        test_modexp_16();
        test_modexp_8();
        test_error();
        test_irq();
        test_abort();
        test_back_to_back();
        test_index();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "time limit reached");
    end
endmodule
